// File: rtl/mem_ctrl_pkg.sv
// Shared constants, state/source encodings and size decode for mem_ctrl.
package mem_ctrl_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic BUSY    = 1'b1;
  localparam logic IDLE    = 1'b0;

  localparam logic [31:0] ZERO32 = 32'h0000_0000;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Index into the per-source latch array
  typedef enum logic {
    SRC_IC  = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  function automatic logic [2:0] size_len(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_len = 3'd1;
      SZ_HALF: size_len = 3'd2;
      default: size_len = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_req_latch.sv
// Pending-request holder: a flag plus payload; a new request (set) wins over clear.
module mem_ctrl_req_latch #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         set_i,
  input  logic         clr_i,
  input  logic [W-1:0] data_i,
  output logic         pend_o,
  output logic [W-1:0] data_o
);

  logic         pend_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
      data_q <= '0;
    end else if (en_i) begin
      if (set_i) begin
        pend_q <= 1'b1;
        data_q <= data_i;
      end else if (clr_i) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign pend_o = pend_q;
  assign data_o = data_q;

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serialising arbiter between I-fetch and MEM in front of the RAM/IO bus.
// Optional IO write back-pressure is enabled with `define MC_IO_STALL_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                ADDR_W  = 18,
  parameter logic [ADDR_W-1:0] IO_ADDR = 18'h30000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              jump_in,
  input  logic              ic_req_in,
  input  logic [ADDR_W-1:0] ic_addr_in,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [1:0]        mem_size_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [31:0]       mem_wdata_in,
  input  logic              io_full_in,
  input  logic [7:0]        ram_din_in,
  output logic [7:0]        ram_dout_out,
  output logic [31:0]       ram_addr_out,
  output logic              ram_wr_out,
  output logic              ic_valid_out,
  output logic [31:0]       ic_inst_out,
  output logic              mem_done_out,
  output logic [31:0]       mem_rdata_out,
  output logic              busy_ic_out,
  output logic              busy_mem_out
);

  // Payload layout: {addr, size, we, wdata}
  localparam int PW = ADDR_W + 35;

  logic [1:0]         req_in, req_set, req_clr, req_pend, eff_vld, grant;
  logic [1:0][PW-1:0] req_pl, req_q, eff_pl;
  logic [PW-1:0]      sel_pl;

  state_e            state_q, state_d;
  src_e              src_q, src_d;
  logic [2:0]        cnt_q, cnt_d, len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d, bus_addr;
  logic [31:0]       wdata_q, wdata_d, asm_q, asm_d;
  logic [31:0]       ic_inst_q, ic_inst_d, mem_rdata_q, mem_rdata_d;
  logic              io_stall;

  assign req_in    = {mem_req_in, ic_req_in};
  assign req_pl[0] = {ic_addr_in, SZ_WORD, 1'b0, ZERO32};
  assign req_pl[1] = {mem_addr_in, mem_size_in, mem_we_in, mem_wdata_in};

  for (genvar s = 0; s < 2; s++) begin : g_src
    mem_ctrl_req_latch #(.W(PW)) u_lat (
      .clk_i  (clk_in),
      .rst_i  (rst_in),
      .en_i   (rdy_in),
      .set_i  (req_set[s]),
      .clr_i  (req_clr[s]),
      .data_i (req_pl[s]),
      .pend_o (req_pend[s]),
      .data_o (req_q[s])
    );
  end

`ifdef MC_IO_STALL_EN
  assign io_stall = (state_q == ST_WRITE) && (base_q >= IO_ADDR) && io_full_in;
`else
  logic unused_io;
  assign unused_io = ^{io_full_in, IO_ADDR};
  assign io_stall  = 1'b0;
`endif

  // A jump kills a stale pending fetch, but a fetch arriving with it is the new PC
  always_comb begin
    eff_vld[0] = ic_req_in | (req_pend[0] & ~jump_in);
    eff_vld[1] = mem_req_in | req_pend[1];
    for (int s = 0; s < 2; s++) eff_pl[s] = req_in[s] ? req_pl[s] : req_q[s];
    grant[1] = (state_q == ST_IDLE) & eff_vld[1];
    grant[0] = (state_q == ST_IDLE) & ~eff_vld[1] & eff_vld[0];
    req_set  = req_in & ~grant;
    req_clr  = grant | {1'b0, jump_in};
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    ic_inst_d   = ic_inst_q;
    mem_rdata_d = mem_rdata_q;
    sel_pl      = '0;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          sel_pl  = grant[1] ? eff_pl[1] : eff_pl[0];
          src_d   = grant[1] ? SRC_MEM : SRC_IC;
          base_d  = sel_pl[PW-1 -: ADDR_W];
          len_d   = size_len(sel_pl[34:33]);
          wdata_d = sel_pl[31:0];
          cnt_d   = 3'd0;
          asm_d   = ZERO32;
          state_d = sel_pl[32] ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        if (src_q == SRC_IC && jump_in) begin
          state_d = ST_IDLE;
        end else begin
          // Byte addressed in cycle k-1 arrives now
          case (cnt_q)
            3'd1:    asm_d[7:0]   = ram_din_in;
            3'd2:    asm_d[15:8]  = ram_din_in;
            3'd3:    asm_d[23:16] = ram_din_in;
            3'd4:    asm_d[31:24] = ram_din_in;
            default: ;
          endcase
          if (cnt_q == len_q) begin
            state_d = ST_DONE;
            if (src_q == SRC_IC) ic_inst_d = asm_d;
            else                 mem_rdata_d = asm_d;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_WRITE: begin
        if (!io_stall) begin
          if (cnt_q == len_q - 3'd1) state_d = ST_DONE;
          else                       cnt_d   = cnt_q + 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      src_q       <= SRC_IC;
      cnt_q       <= '0;
      len_q       <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      ic_inst_q   <= '0;
      mem_rdata_q <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      src_q       <= src_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      ic_inst_q   <= ic_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign bus_addr = base_q + ADDR_W'(cnt_q);

  always_comb begin
    ram_addr_out = ZERO32;
    ram_dout_out = 8'h00;
    ram_wr_out   = DISABLE;
    if (state_q == ST_READ && cnt_q < len_q) begin
      ram_addr_out = {{(32-ADDR_W){1'b0}}, bus_addr};
    end else if (state_q == ST_WRITE) begin
      ram_addr_out = {{(32-ADDR_W){1'b0}}, bus_addr};
      ram_wr_out   = rdy_in & ~io_stall;
      case (cnt_q[1:0])
        2'd0:    ram_dout_out = wdata_q[7:0];
        2'd1:    ram_dout_out = wdata_q[15:8];
        2'd2:    ram_dout_out = wdata_q[23:16];
        default: ram_dout_out = wdata_q[31:24];
      endcase
    end
  end

  assign ic_valid_out  = rdy_in && state_q == ST_DONE && src_q == SRC_IC && !jump_in;
  assign mem_done_out  = rdy_in && state_q == ST_DONE && src_q == SRC_MEM;
  assign ic_inst_out   = ic_inst_q;
  assign mem_rdata_out = mem_rdata_q;
  // A queued fetch counts as busy so the cache does not re-issue it
  assign busy_ic_out   = req_pend[0] | (state_q != ST_IDLE && src_q == SRC_IC);
  assign busy_mem_out  = req_pend[1] | (state_q != ST_IDLE && src_q == SRC_MEM);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide RAM model on the bus.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, jump_in, ic_req_in, mem_req_in, mem_we_in, io_full_in;
  logic [17:0] ic_addr_in, mem_addr_in;
  logic [1:0]  mem_size_in;
  logic [31:0] mem_wdata_in;
  logic [7:0]  ram_din_in = 8'h00;
  logic [7:0]  ram_dout_out;
  logic [31:0] ram_addr_out, ic_inst_out, mem_rdata_out;
  logic        ram_wr_out, ic_valid_out, mem_done_out, busy_ic_out, busy_mem_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ram [logic [31:0]];

  always #5 clk_in = ~clk_in;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .jump_in(jump_in),
    .ic_req_in(ic_req_in), .ic_addr_in(ic_addr_in),
    .mem_req_in(mem_req_in), .mem_we_in(mem_we_in), .mem_size_in(mem_size_in),
    .mem_addr_in(mem_addr_in), .mem_wdata_in(mem_wdata_in), .io_full_in(io_full_in),
    .ram_din_in(ram_din_in), .ram_dout_out(ram_dout_out), .ram_addr_out(ram_addr_out),
    .ram_wr_out(ram_wr_out), .ic_valid_out(ic_valid_out), .ic_inst_out(ic_inst_out),
    .mem_done_out(mem_done_out), .mem_rdata_out(mem_rdata_out),
    .busy_ic_out(busy_ic_out), .busy_mem_out(busy_mem_out)
  );

  always @(posedge clk_in) begin
    ram_din_in <= ram.exists(ram_addr_out) ? ram[ram_addr_out] : 8'h00;
    if (ram_wr_out) ram[ram_addr_out] = ram_dout_out;
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    logic [105:0] obs;
    rst_in = 1'b1; rdy_in = 1'b0; jump_in = 1'b0; ic_req_in = 1'b0; mem_req_in = 1'b0;
    mem_we_in = 1'b0; io_full_in = 1'b0; ic_addr_in = '0; mem_addr_in = '0;
    mem_size_in = 2'd0; mem_wdata_in = '0;
    repeat (3) step();
    obs = {ram_addr_out, ram_dout_out, ram_wr_out, ic_valid_out, ic_inst_out,
           mem_done_out, mem_rdata_out, busy_ic_out, busy_mem_out};
    n_tests++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    rst_in = 1'b0; rdy_in = 1'b1;
    step();
  endtask

  task automatic test_fetch();
    int first = -1;
    int pulses = 0;
    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    ic_req_in = 1'b1; ic_addr_in = 18'h00100;
    step();
    ic_req_in = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      if (n == 1) begin
        n_tests++;
        if (ram_addr_out !== 32'h100 || ram_wr_out !== 1'b0 || busy_ic_out !== 1'b1) begin
          n_fail++;
          $display("FAIL fetch_first_addr got addr=%h wr=%b busy=%b exp addr=100 wr=0 busy=1",
                   ram_addr_out, ram_wr_out, busy_ic_out);
        end
      end
      if (ic_valid_out === 1'b1) begin
        pulses++;
        if (first < 0) first = n;
      end
      step();
    end
    n_tests++;
    if (first != 6) begin n_fail++; $display("FAIL fetch_latency got=%0d exp=6", first); end
    n_tests++;
    if (pulses != 1) begin n_fail++; $display("FAIL fetch_pulses got=%0d exp=1", pulses); end
    n_tests++;
    if (ic_inst_out !== 32'h00000513) begin
      n_fail++; $display("FAIL fetch_inst got=%h exp=00000513", ic_inst_out);
    end
    n_tests++;
    if (busy_ic_out !== 1'b0) begin n_fail++; $display("FAIL fetch_busy_clear got=%b exp=0", busy_ic_out); end
  endtask

  task automatic test_store_word();
    logic [7:0] exp_b [4];
    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    mem_req_in = 1'b1; mem_we_in = 1'b1; mem_size_in = 2'd2;
    mem_addr_in = 18'h00200; mem_wdata_in = 32'hDEADBEEF;
    step();
    mem_req_in = 1'b0; mem_we_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (ram_wr_out !== 1'b1 || ram_addr_out !== 32'h200 + k || ram_dout_out !== exp_b[k]) begin
        n_fail++;
        $display("FAIL store_cycle%0d got wr=%b addr=%h dout=%h exp wr=1 addr=%h dout=%h",
                 k, ram_wr_out, ram_addr_out, ram_dout_out, 32'h200 + k, exp_b[k]);
      end
      step();
    end
    n_tests++;
    if (mem_done_out !== 1'b1 || ram_wr_out !== 1'b0) begin
      n_fail++; $display("FAIL store_done got done=%b wr=%b exp done=1 wr=0", mem_done_out, ram_wr_out);
    end
    step();
    n_tests++;
    if (mem_done_out !== 1'b0 || ram_addr_out !== 32'h0 || busy_mem_out !== 1'b0) begin
      n_fail++;
      $display("FAIL store_after got done=%b addr=%h busy=%b exp 0/0/0", mem_done_out, ram_addr_out, busy_mem_out);
    end
  endtask

  task automatic test_simultaneous();
    int mem_first = -1;
    int ic_first = -1;
    int busy_drop = 0;
    logic [31:0] rdata = '0;
    ram[32'h10] = 8'h80;
    ic_req_in = 1'b1; ic_addr_in = 18'h00100;
    mem_req_in = 1'b1; mem_we_in = 1'b0; mem_size_in = 2'd0; mem_addr_in = 18'h00010;
    step();
    ic_req_in = 1'b0; mem_req_in = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      if (ic_first < 0 && busy_ic_out !== 1'b1) busy_drop++;
      if (mem_done_out === 1'b1 && mem_first < 0) begin mem_first = n; rdata = mem_rdata_out; end
      if (ic_valid_out === 1'b1 && ic_first < 0) ic_first = n;
      step();
    end
    n_tests++;
    if (mem_first != 3) begin n_fail++; $display("FAIL simul_mem_cycle got=%0d exp=3", mem_first); end
    n_tests++;
    if (rdata !== 32'h00000080) begin n_fail++; $display("FAIL simul_mem_rdata got=%h exp=00000080", rdata); end
    n_tests++;
    if (ic_first != 10) begin n_fail++; $display("FAIL simul_ic_cycle got=%0d exp=10", ic_first); end
    n_tests++;
    if (busy_drop != 0) begin n_fail++; $display("FAIL simul_busy_ic got drops=%0d exp=0", busy_drop); end
    n_tests++;
    if (ic_inst_out !== 32'h00000513) begin n_fail++; $display("FAIL simul_inst got=%h exp=00000513", ic_inst_out); end
  endtask

  task automatic test_jump();
    int pulses = 0;
    ram[32'h104] = 8'hAA; ram[32'h105] = 8'hBB; ram[32'h106] = 8'hCC; ram[32'h107] = 8'hDD;
    ic_req_in = 1'b1; ic_addr_in = 18'h00104;
    step();
    ic_req_in = 1'b0;
    step();
    jump_in = 1'b1;
    #1;
    if (ic_valid_out === 1'b1) pulses++;
    step();
    jump_in = 1'b0;
    #1;
    n_tests++;
    if (busy_ic_out !== 1'b0 || ram_addr_out !== 32'h0 || ram_wr_out !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_abort got busy=%b addr=%h wr=%b exp 0/0/0", busy_ic_out, ram_addr_out, ram_wr_out);
    end
    for (int n = 3; n <= 10; n++) begin
      if (ic_valid_out === 1'b1) pulses++;
      step();
    end
    n_tests++;
    if (pulses != 0) begin n_fail++; $display("FAIL jump_no_valid got=%0d exp=0", pulses); end
    n_tests++;
    if (ic_inst_out !== 32'h00000513) begin n_fail++; $display("FAIL jump_inst_held got=%h exp=00000513", ic_inst_out); end
  endtask

  task automatic test_rdy_stall();
    mem_req_in = 1'b1; mem_we_in = 1'b1; mem_size_in = 2'd1;
    mem_addr_in = 18'h00300; mem_wdata_in = 32'h12345678;
    step();
    mem_req_in = 1'b0; mem_we_in = 1'b0;
    n_tests++;
    if (ram_wr_out !== 1'b1 || ram_addr_out !== 32'h300 || ram_dout_out !== 8'h78) begin
      n_fail++;
      $display("FAIL rdy_byte0 got wr=%b addr=%h dout=%h exp 1/300/78", ram_wr_out, ram_addr_out, ram_dout_out);
    end
    step();
    rdy_in = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      n_tests++;
      if (ram_wr_out !== 1'b0 || mem_done_out !== 1'b0) begin
        n_fail++; $display("FAIL rdy_low%0d got wr=%b done=%b exp 0/0", n, ram_wr_out, mem_done_out);
      end
      step();
    end
    rdy_in = 1'b1;
    #1;
    n_tests++;
    if (ram_wr_out !== 1'b1 || ram_addr_out !== 32'h301 || ram_dout_out !== 8'h56) begin
      n_fail++;
      $display("FAIL rdy_byte1 got wr=%b addr=%h dout=%h exp 1/301/56", ram_wr_out, ram_addr_out, ram_dout_out);
    end
    step();
    n_tests++;
    if (mem_done_out !== 1'b1) begin n_fail++; $display("FAIL rdy_done got=%b exp=1", mem_done_out); end
    step();
    n_tests++;
    if ({ram[32'h301], ram[32'h300]} !== 16'h5678) begin
      n_fail++; $display("FAIL rdy_ram got=%h exp=5678", {ram[32'h301], ram[32'h300]});
    end
  endtask

  task automatic test_wrap();
    ram[32'h3FFFF] = 8'hAB; ram[32'h0] = 8'hCD;
    mem_req_in = 1'b1; mem_we_in = 1'b0; mem_size_in = 2'd1; mem_addr_in = 18'h3FFFF;
    step();
    mem_req_in = 1'b0;
    n_tests++;
    if (ram_addr_out !== 32'h3FFFF) begin n_fail++; $display("FAIL wrap_addr0 got=%h exp=3ffff", ram_addr_out); end
    repeat (3) step();
    n_tests++;
    if (mem_done_out !== 1'b1 || mem_rdata_out !== 32'h0000CDAB) begin
      n_fail++; $display("FAIL wrap_load got done=%b data=%h exp 1/0000cdab", mem_done_out, mem_rdata_out);
    end
    step();
  endtask

  task automatic test_io();
    int writes = 0;
    io_full_in = 1'b1;
    mem_req_in = 1'b1; mem_we_in = 1'b1; mem_size_in = 2'd0;
    mem_addr_in = 18'h30000; mem_wdata_in = 32'h00000041;
    step();
    mem_req_in = 1'b0; mem_we_in = 1'b0;
`ifdef MC_IO_STALL_EN
    for (int n = 1; n <= 5; n++) begin
      n_tests++;
      if (ram_wr_out !== 1'b0) begin n_fail++; $display("FAIL io_stall%0d got wr=%b exp=0", n, ram_wr_out); end
      step();
    end
    io_full_in = 1'b0;
    #1;
`endif
    for (int n = 0; n < 4; n++) begin
      if (n == 0) begin
        n_tests++;
        if (ram_wr_out !== 1'b1 || ram_addr_out !== 32'h30000 || ram_dout_out !== 8'h41) begin
          n_fail++;
          $display("FAIL io_write got wr=%b addr=%h dout=%h exp 1/30000/41", ram_wr_out, ram_addr_out, ram_dout_out);
        end
      end
      if (n == 1) begin
        n_tests++;
        if (mem_done_out !== 1'b1) begin n_fail++; $display("FAIL io_done got=%b exp=1", mem_done_out); end
      end
      if (ram_wr_out === 1'b1) writes++;
      step();
    end
    io_full_in = 1'b0;
    n_tests++;
    if (writes != 1) begin n_fail++; $display("FAIL io_write_count got=%0d exp=1", writes); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_word();
    test_simultaneous();
    test_jump();
    test_rdy_stall();
    test_wrap();
    test_io();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Single-port arbiter between the instruction cache fetch path and the MEM stage, in front of the byte-wide RAM/IO bus. It serialises 1/2/4-byte requests into per-byte bus cycles and reassembles read data little-endian. MEM has priority over instruction fetches, and a pending fetch can be aborted on a PC jump. It sits directly below the instruction cache, supplying its MC busy/valid/instruction inputs.

Parameters:
ADDR_W, 18, request address width; the bus address is zero-extended to 32 bits.
IO_ADDR, 18'h30000, lowest IO-mapped address; used only by the optional feature.

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global ready; low freezes all state
jump_in  in  1  PC redirect; aborts an in-flight or pending fetch
ic_req_in  in  1  instruction fetch request (one-cycle pulse)
ic_addr_in  in  18  fetch address, word-aligned
mem_req_in  in  1  MEM access request (one-cycle pulse)
mem_we_in  in  1  1 = store, 0 = load
mem_size_in  in  2  0 = byte, 1 = half, 2 = word
mem_addr_in  in  18  MEM address
mem_wdata_in  in  32  store data; low bytes used
io_full_in  in  1  IO buffer full (optional feature)
ram_din_in  in  8  RAM read byte, valid one cycle after address
ram_dout_out  out  8  RAM write byte
ram_addr_out  out  32  RAM byte address
ram_wr_out  out  1  1 = write cycle
ic_valid_out  out  1  one-cycle pulse: instruction ready
ic_inst_out  out  32  fetched instruction
mem_done_out  out  1  one-cycle pulse: MEM access complete
mem_rdata_out  out  32  load data, zero-extended
busy_ic_out  out  1  fetch in flight
busy_mem_out  out  1  MEM access in flight

Behaviour:
- Reset: state IDLE; all outputs 0; pending-fetch latch cleared. Reset has priority over rdy_in.
- rdy_in = 0: no register updates; ram_wr_out is forced to 0 combinationally.
- Request latching: ic_req_in and mem_req_in are latched into pending registers (addr, size, we, wdata) when they arrive, in any state.
- States: IDLE, READ, WRITE, DONE. A byte counter cnt[2:0] and a total byte count len (1, 2 or 4) are kept.
- IDLE arbitration: a pending MEM request wins over a pending fetch.
  - A fetch is taken only if no MEM request is pending or arriving in the same cycle.
  - Taking a request: base addr latched, cnt = 0, enter READ or WRITE, busy_* set for the granted source.
- READ: cycle k drives ram_addr_out = base + k while cnt < len. The byte arriving in cycle k+1 lands in bits [8k+7:8k].
  - Read latency: len + 1 cycles from entering READ, then DONE.
- WRITE: cycle k drives addr base + k, ram_dout_out = wdata byte k, ram_wr_out = 1. After len cycles, go to DONE.
- DONE (one cycle):
  - Pulse ic_valid_out or mem_done_out, with data on ic_inst_out or mem_rdata_out.
  - Clear the matching busy bit and return to IDLE. Output data is held until the next completion.
- jump_in:
  - Clears the pending fetch.
  - If the current access is a fetch (READ/DONE for the IC source): return to IDLE next cycle, suppress ic_valid_out, clear busy_ic_out.
  - A MEM access is never aborted.
  - A fetch request in the same cycle as jump_in is accepted, not dropped: the new address belongs to the redirected PC.
- Simultaneous requests in IDLE: MEM is served first. The fetch stays pending and starts in the cycle after MEM's DONE.
- Address wrap: base + k is computed in ADDR_W bits and wraps modulo 2^18.
- Bus idle: when not in READ/WRITE, ram_addr_out = 0, ram_wr_out = 0, ram_dout_out = 0.

Optional Feature:
MC_IO_STALL_EN.
- Defined: a WRITE whose base address >= IO_ADDR stalls while io_full_in = 1.
  - During the stall: ram_wr_out = 0 and cnt holds.
  - The write resumes on the first cycle io_full_in = 0, so the completion pulse is delayed by the stall length.
- Undefined: io_full_in is ignored and IO writes proceed immediately.

Decomposition:
- Shared defines header: Enable/Disable, Busy/Idle, state encodings, size codes, ZERO32.
- Sub-module mem_ctrl_req_latch: one instance per source, holding the pending flag and payload with set/clear.

Test Plan:
- Fetch from 0x00100, RAM bytes 13 05 00 00 -> ic_valid_out pulses 6 cycles after grant-cycle entry to READ; ic_inst_out = 0x00000513.
- MEM store word 0xDEADBEEF at 0x00200 -> four write cycles on addresses 0x200..0x203 with bytes EF BE AD DE, then mem_done_out pulses.
- ic_req_in and mem_req_in (load byte at 0x00010, RAM = 0x80) in the same cycle -> MEM done first with mem_rdata_out = 0x00000080; the fetch then starts; busy_ic_out stays 1 throughout.
- jump_in in the 2nd cycle of a fetch READ -> no ic_valid_out; busy_ic_out = 0 next cycle; the bus is idle.
- rdy_in low for 3 cycles mid-store of a half-word -> ram_wr_out = 0 while low; the store completes with correct bytes after rdy_in returns.
- MC_IO_STALL_EN defined: store byte 0x41 to 0x30000 with io_full_in high for 5 cycles -> no write until io_full_in falls; then a single write of 0x41.
